// File: rtl/hack_memory_bus_if.sv
// Bundles the Hack CPU data bus, the screen-write stream and the keyboard/vsync inputs.
// The slave modport is the memory bus; the master side is the CPU plus its peripherals.
interface hack_memory_bus_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready;
  logic        key_valid;
  logic [15:0] key_code;
  logic        vsync;

  modport slave (
    input  addressM, outM, writeM, scr_ready, key_valid, key_code, vsync,
    output inM, scr_valid, scr_addr, scr_data
  );

  modport master (
    output addressM, outM, writeM, scr_ready, key_valid, key_code, vsync,
    input  inM, scr_valid, scr_addr, scr_data
  );
endinterface

// File: rtl/hack_memory_bus.sv
// Hack data-memory map: async-read RAM, screen-write FIFO (push to scr_valid in 1 cycle), KBD, STATUS.
// Screen writes stall nothing: a write into a full FIFO without a same-cycle pop is dropped and flagged.
module hack_memory_bus #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_WORDS  = 16384
) (
  input logic             clk,
  input logic             reset,
  hack_memory_bus_if.slave bus
);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int RAM_AW = $clog2(RAM_WORDS);

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_entry_t;

  logic [15:0] ram [RAM_WORDS];
  scr_entry_t  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   kbd;
  logic          overflow, frame, vsync_q;

  logic sel_ram, sel_scr, sel_kbd, sel_status;
  logic fifo_full, push_req, push, pop, overflow_set, frame_set;
  logic [1:0] status_clr;

  assign sel_ram    = (bus.addressM[14] == 1'b0);
  assign sel_scr    = (bus.addressM[14:13] == 2'b10);
  assign sel_kbd    = (bus.addressM == 15'h6000);
  assign sel_status = (bus.addressM == 15'h6001);

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign pop       = bus.scr_valid && bus.scr_ready;
  assign push_req  = bus.writeM && sel_scr && !reset;
  // A pop in the same cycle frees the slot the push lands in, so full+pop still accepts.
  assign push         = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;
  assign frame_set    = bus.vsync && !vsync_q;
  assign status_clr   = (bus.writeM && sel_status) ? bus.outM[1:0] : 2'b00;

  assign bus.scr_valid = (count != '0);
  assign bus.scr_addr  = fifo_mem[rd_ptr].addr;
  assign bus.scr_data  = fifo_mem[rd_ptr].data;

  always_ff @(posedge clk) begin
    if (!reset && bus.writeM && sel_ram)
      ram[bus.addressM[RAM_AW-1:0]] <= bus.outM;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr].addr <= bus.addressM[12:0];
      fifo_mem[wr_ptr].data <= bus.outM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      kbd      <= 16'h0000;
      overflow <= 1'b0;
      frame    <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (bus.key_valid)
        kbd <= bus.key_code;
      // Set has priority over a coincident write-1-to-clear.
      overflow <= overflow_set | (overflow & ~status_clr[0]);
      frame    <= frame_set    | (frame    & ~status_clr[1]);
      vsync_q  <= bus.vsync;
    end
  end

  always_comb begin
    bus.inM = 16'h0000;
    if (sel_ram)
      bus.inM = ram[bus.addressM[RAM_AW-1:0]];
    else if (sel_kbd)
      bus.inM = kbd;
    else if (sel_status)
      bus.inM = {13'b0, fifo_full, frame, overflow};
  end
endmodule

// File: tb/tb_hack_memory_bus.sv
// Directed bench for hack_memory_bus: RAM, screen FIFO, KBD, STATUS and reset behaviour.
module tb_hack_memory_bus;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  hack_memory_bus_if bus ();

  hack_memory_bus #(.FIFO_DEPTH(4), .RAM_WORDS(16384)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    bus.addressM = a;
    bus.outM     = d;
    bus.writeM   = 1'b1;
    tick();
    bus.writeM   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [14:0] a, input logic [15:0] exp);
    bus.addressM = a;
    #1;
    check(tag, bus.inM, exp);
  endtask

  initial begin
    reset         = 1'b1;
    bus.addressM  = '0;
    bus.outM      = '0;
    bus.writeM    = 1'b0;
    bus.scr_ready = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.vsync     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_scr_valid", 16'(bus.scr_valid), 16'h0000);
    read_chk("rst_status", 15'h6001, 16'h0000);
    read_chk("rst_kbd", 15'h6000, 16'h0000);

    // RAM write/read, read-old-on-same-cycle, unmapped and screen reads
    cpu_write(15'h0005, 16'h1234);
    read_chk("ram_rd", 15'h0005, 16'h1234);
    bus.addressM = 15'h0005;
    bus.outM     = 16'hBEEF;
    bus.writeM   = 1'b1;
    #1;
    check("ram_same_cycle_old", bus.inM, 16'h1234);
    tick();
    bus.writeM = 1'b0;
    read_chk("ram_rd_new", 15'h0005, 16'hBEEF);
    read_chk("unmapped_7fff", 15'h7FFF, 16'h0000);
    read_chk("unmapped_6002", 15'h6002, 16'h0000);
    read_chk("screen_rd", 15'h4000, 16'h0000);
    cpu_write(15'h6000, 16'hFFFF);
    read_chk("kbd_write_ignored", 15'h6000, 16'h0000);
    cpu_write(15'h7000, 16'h5555);
    read_chk("unmapped_write_ignored", 15'h7000, 16'h0000);

    // Five screen writes into a 4-deep FIFO with the consumer stalled
    bus.scr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_write(15'h4000 + 15'(i), 16'hA000 + 16'(i));
      if (i == 0) begin
        check("first_word_latency", 16'(bus.scr_valid), 16'h0001);
        check("first_word_addr", 16'(bus.scr_addr), 16'h0000);
      end
    end
    read_chk("status_overflow_full", 15'h6001, 16'h0005);
    tick();
    check("head_hold_addr", 16'(bus.scr_addr), 16'h0000);
    check("head_hold_data", bus.scr_data, 16'hA000);
    bus.scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", 16'(bus.scr_addr), 16'(i));
      check("drain_data", bus.scr_data, 16'hA000 + 16'(i));
      tick();
    end
    check("drain_empty", 16'(bus.scr_valid), 16'h0000);
    bus.scr_ready = 1'b0;
    cpu_write(15'h6001, 16'h0001);
    read_chk("overflow_cleared", 15'h6001, 16'h0000);

    // Push and pop on a full FIFO in the same cycle
    for (int i = 0; i < 4; i++)
      cpu_write(15'h4000 + 15'(i), 16'hB000 + 16'(i));
    read_chk("full_status", 15'h6001, 16'h0004);
    bus.scr_ready = 1'b1;
    bus.addressM  = 15'h4010;
    bus.outM      = 16'hC010;
    bus.writeM    = 1'b1;
    tick();
    bus.writeM = 1'b0;
    read_chk("push_pop_full_no_ovf", 15'h6001, 16'h0004);
    begin
      logic [12:0] exp_a [4];
      logic [15:0] exp_d [4];
      exp_a[0] = 13'h1;  exp_d[0] = 16'hB001;
      exp_a[1] = 13'h2;  exp_d[1] = 16'hB002;
      exp_a[2] = 13'h3;  exp_d[2] = 16'hB003;
      exp_a[3] = 13'h10; exp_d[3] = 16'hC010;
      for (int i = 0; i < 4; i++) begin
        check("pp_order_addr", 16'(bus.scr_addr), 16'(exp_a[i]));
        check("pp_order_data", bus.scr_data, exp_d[i]);
        tick();
      end
    end
    check("pp_empty", 16'(bus.scr_valid), 16'h0000);
    bus.scr_ready = 1'b0;

    // Keyboard latch
    bus.key_code  = 16'h0083;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 16'h1234;
    tick();
    tick();
    read_chk("kbd_0083", 15'h6000, 16'h0083);
    bus.key_code  = 16'h0000;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    read_chk("kbd_release", 15'h6000, 16'h0000);

    // vsync edge detection, level does not re-set after a clear, set beats clear
    bus.vsync = 1'b1;
    tick();
    read_chk("frame_set", 15'h6001, 16'h0002);
    tick();
    cpu_write(15'h6001, 16'h0002);
    bus.vsync = 1'b0;
    read_chk("frame_clear_level_high", 15'h6001, 16'h0000);
    tick();
    bus.vsync = 1'b1;
    cpu_write(15'h6001, 16'h0002);
    bus.vsync = 1'b0;
    read_chk("frame_set_wins", 15'h6001, 16'h0002);

    // Reset with 3 queued entries, overflow and frame set
    for (int i = 0; i < 5; i++)
      cpu_write(15'h4000 + 15'(i), 16'hD000 + 16'(i));
    bus.scr_ready = 1'b1;
    tick();
    bus.scr_ready = 1'b0;
    read_chk("pre_reset_status", 15'h6001, 16'h0003);
    bus.key_code  = 16'h0055;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    read_chk("pre_reset_kbd", 15'h6000, 16'h0055);
    reset         = 1'b1;
    bus.addressM  = 15'h4005;
    bus.outM      = 16'hEEEE;
    bus.writeM    = 1'b1;
    bus.key_code  = 16'h0077;
    bus.key_valid = 1'b1;
    bus.vsync     = 1'b1;
    tick();
    reset         = 1'b0;
    bus.writeM    = 1'b0;
    bus.key_valid = 1'b0;
    bus.vsync     = 1'b0;
    check("reset_scr_valid", 16'(bus.scr_valid), 16'h0000);
    read_chk("reset_status", 15'h6001, 16'h0000);
    read_chk("reset_kbd", 15'h6000, 16'h0000);
    read_chk("reset_ram_kept", 15'h0005, 16'hBEEF);
    tick();
    check("reset_no_push", 16'(bus.scr_valid), 16'h0000);
    read_chk("reset_no_frame", 15'h6001, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
